scan_test_ctrl: RTL
===================

# scan_test_ctrl

Sequencer that drives one scan chain of SCAN_FF cells and checks the result. It loads a test pattern through the chain's TE/TI inputs, pulses one functional capture, and unloads the chain from its scan-out. It then compares the captured response against an expected vector under a mask. It sits directly upstream of the chain, drives every cell's TE and the first cell's TI, and consumes the last cell's Q.

## Interface
- CHAIN_LEN, 16: number of scan cells in the chain (≥2).
- CAPTURE_CYCLES, 1: number of cycles TE is held low for functional capture (≥1).
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a test; sampled only in IDLE.
- ABORT  in  1  synchronous abort; returns to IDLE from any state.
- PATTERN  in  CHAIN_LEN  value to load; cell k (k=0 nearest TI) receives PATTERN[k].
- EXPECT  in  CHAIN_LEN  expected captured value per cell.
- MASK  in  CHAIN_LEN  1 = ignore that cell in the compare.
- SO  in  1  Q of cell CHAIN_LEN-1.
- TE  out  1  scan enable to all cells.
- TI  out  1  scan data into cell 0.
- RESPONSE  out  CHAIN_LEN  captured value per cell, valid when DONE.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at test completion.
- PASS  out  1  compare result; valid from DONE and held until the next START.

## Operation
- All outputs are registered.
- Reset values: TE=0, TI=0, BUSY=0, DONE=0, PASS=0, RESPONSE=0, state IDLE, counters 0.
- **IDLE.** When START=1, latch PATTERN, EXPECT and MASK, clear PASS, and go to LOAD. START is ignored in every other state.
- **LOAD.** Lasts CHAIN_LEN cycles, with TE=1.
  - TI presents PATTERN[CHAIN_LEN-1-i] in load cycle i (i=0..CHAIN_LEN-1), so the first bit shifted ends in the last cell.
  - After the last load edge, cell k holds PATTERN[k].
- **CAPTURE.** Lasts CAPTURE_CYCLES cycles, with TE=0 and TI=0. The chain clocks its functional D inputs.
- **UNLOAD.** Lasts CHAIN_LEN cycles, with TE=1 and TI=0.
  - In unload cycle j (j=0..CHAIN_LEN-1), the SO value present before the edge is written to RESPONSE[CHAIN_LEN-1-j].
  - The first unload sample is the value cell CHAIN_LEN-1 holds after capture, with no shift before it.
- **DONE.** One cycle.
  - TE=0, DONE=1, BUSY=1.
  - PASS = (((RESPONSE ^ EXPECT) & ~MASK) == 0), evaluated on the complete RESPONSE and registered at entry to this state.
  - Next state: IDLE.
- **ABORT=1 in any non-IDLE state.** Next state is IDLE with TE=0 and TI=0. No DONE pulse; PASS stays 0; RESPONSE holds partial contents. ABORT has priority over all other transitions.
- **ABORT=1 with START=1 in IDLE.** Stay in IDLE.
- **Simultaneous START with DONE.** START is ignored, because the state is not yet IDLE. A new START is accepted on the first cycle BUSY=0.
- **Reset mid-test.** TE drops to 0 asynchronously, so the chain leaves shift mode immediately. All outputs take their reset values.
- **Counters.** Wide enough for max(CHAIN_LEN, CAPTURE_CYCLES). Compare against the terminal count; no wrap beyond it.

## Timing
- **START to first TE=1:** 1 cycle. START is sampled at edge 0; TE=1 and TI=PATTERN[CHAIN_LEN-1] appear after edge 0.
- **Total BUSY duration:** 2·CHAIN_LEN + CAPTURE_CYCLES + 1 cycles.
- **DONE position:** DONE is high in the final BUSY cycle.
- **After DONE:** BUSY falls on the edge after DONE, in the same cycle DONE falls.
- **TE transitions:**
  - LOAD→CAPTURE: TE falls 1→0 at the boundary.
  - CAPTURE→UNLOAD: TE rises 0→1 at the boundary.
  - Glitch-free by construction, because TE is registered.
- **Data and result validity:**
  - TI changes only on rising edges.
  - RESPONSE is stable from the DONE cycle until the next UNLOAD.
  - PASS is stable from the DONE cycle until the next accepted START.

## Test plan
- **Loopback.** CHAIN_LEN=4, CAPTURE_CYCLES=1, a 4-cell SCAN_FF chain with D tied to each cell's own Q, PATTERN=4'b1011, EXPECT=4'b1011, MASK=0.
  - Required: RESPONSE=4'b1011, PASS=1.
  - Required: DONE exactly 10 cycles after the START edge.
- **Mismatch and mask.** D inputs tied to constant 4'b0110, PATTERN=4'b1111.
  - EXPECT=4'b0111, MASK=0: RESPONSE=4'b0110, PASS=0.
  - Same EXPECT with MASK=4'b0001: PASS=1.
- **TI ordering.** PATTERN=4'b0001. Monitor TI over the 4 load cycles.
  - Required TI sequence: 0,0,0,1.
  - Required TE sequence over the whole test: 1,1,1,1,0,1,1,1,1,0.
- **Abort.** ABORT=1 in load cycle 2.
  - Required: next cycle TE=0, BUSY=0, no DONE, PASS=0.
  - Required: a following START runs a full test normally.
- **Async reset.** RESET_N=0 mid-UNLOAD, between edges.
  - Required: TE=0 and BUSY=0 before the next edge.
  - Required: RESPONSE=0 and PASS=0.
- **Back-to-back.** START held high continuously.
  - Required: a second test starts on the cycle after DONE, with 1 idle cycle between BUSY periods.
  - Required: START during BUSY has no effect on sequencing.

Source files
------------

// File: rtl/scan_test_ctrl.sv
// -----------------------------------------------------------------------------
// scan_test_ctrl
//
// Sequencer for a single scan chain of CHAIN_LEN cells. A test loads PATTERN
// serially through TI with TE high, drops TE for CAPTURE_CYCLES functional
// clocks, then raises TE again to shift the captured state out of SO into
// RESPONSE. The response is compared against EXPECT, with MASK bits ignored.
//
// Ports
//   CLK       system clock, rising edge active
//   RESET_N   asynchronous active-low reset
//   START     begin a test (honoured only in IDLE)
//   ABORT     synchronous abort back to IDLE, highest priority
//   PATTERN   load value; cell k receives PATTERN[k]
//   EXPECT    expected captured value per cell
//   MASK      1 = ignore that cell in the compare
//   SO        scan-out of the last cell
//   TE        scan enable to every cell (registered)
//   TI        scan data into cell 0 (registered)
//   RESPONSE  captured value per cell, complete when DONE
//   BUSY      high in every state except IDLE
//   DONE      one-cycle completion pulse
//   PASS      masked compare result, held until the next accepted START
// -----------------------------------------------------------------------------
module scan_test_ctrl #(
  parameter int CHAIN_LEN      = 16,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic [CHAIN_LEN-1:0] EXPECT,
  input  logic [CHAIN_LEN-1:0] MASK,
  input  logic                 SO,
  output logic                 TE,
  output logic                 TI,
  output logic [CHAIN_LEN-1:0] RESPONSE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS
);

  localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Masked compare: a cell fails only if it differs and is not masked.
  function automatic logic masked_match(input logic [CHAIN_LEN-1:0] resp,
                                        input logic [CHAIN_LEN-1:0] exp_v,
                                        input logic [CHAIN_LEN-1:0] msk);
    return (((resp ^ exp_v) & ~msk) == {CHAIN_LEN{1'b0}});
  endfunction

  state_t               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [CHAIN_LEN-1:0] shift_q,    shift_d;     // pattern, MSB is next TI bit
  logic [CHAIN_LEN-1:0] expect_q,   expect_d;
  logic [CHAIN_LEN-1:0] mask_q,     mask_d;
  logic [CHAIN_LEN-1:0] response_q, response_d;
  logic                 te_q,       te_d;
  logic                 ti_q,       ti_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 pass_q,     pass_d;
  logic [CNT_W-1:0]     resp_idx_s;

  // Unload cycle j writes the pre-edge SO into RESPONSE[CHAIN_LEN-1-j].
  assign resp_idx_s = SHIFT_LAST - cnt_q;

  // Next-state, counter, data path and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    expect_d   = expect_q;
    mask_d     = mask_q;
    response_d = response_q;
    pass_d     = pass_q;

    if (ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && !ABORT) begin
            shift_d  = PATTERN;
            expect_d = EXPECT;
            mask_d   = MASK;
            pass_d   = 1'b0;
            cnt_d    = CNT_ZERO;
            state_d  = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (cnt_q == SHIFT_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = ST_CAPTURE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            shift_d = {shift_q[CHAIN_LEN-2:0], 1'b0};
          end
        end
        ST_CAPTURE: begin
          if (cnt_q == CAP_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = ST_UNLOAD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_UNLOAD: begin
          response_d[resp_idx_s] = SO;
          if (cnt_q == SHIFT_LAST) begin
            cnt_d   = CNT_ZERO;
            // Compare the response including the bit written on this edge.
            pass_d  = masked_match(response_d, expect_q, mask_q);
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // Outputs are a function of the state being entered, so they register
    // cleanly alongside it; TI follows the top of the pattern shifter.
    te_d   = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
    ti_d   = (state_d == ST_LOAD) ? shift_d[CHAIN_LEN-1] : 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset forces TE low without waiting for a clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      shift_q    <= {CHAIN_LEN{1'b0}};
      expect_q   <= {CHAIN_LEN{1'b0}};
      mask_q     <= {CHAIN_LEN{1'b0}};
      response_q <= {CHAIN_LEN{1'b0}};
      te_q       <= 1'b0;
      ti_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      expect_q   <= expect_d;
      mask_q     <= mask_d;
      response_q <= response_d;
      te_q       <= te_d;
      ti_q       <= ti_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign TE       = te_q;
  assign TI       = ti_q;
  assign RESPONSE = response_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;

endmodule
